// File: rtl/aes_encipher_block_p.sv
// AES encipher round datapath with a configurable number of S-box lanes.
// Runs the init, main and final rounds of one 128-bit block for AES-128/192/256.
// Supports abort and raises a one-cycle result_valid strobe when a block finishes.
module aes_encipher_block_p #(
    parameter int NUM_SBOX_WORDS = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          next,
    input  logic                          abort,
    input  logic [1:0]                    keylen,
    output logic [3:0]                    round,
    input  logic [127:0]                  round_key,
    input  logic [127:0]                  block,
    output logic [32*NUM_SBOX_WORDS-1:0]  sboxw,
    input  logic [32*NUM_SBOX_WORDS-1:0]  new_sboxw,
    output logic [127:0]                  new_block,
    output logic                          ready,
    output logic                          result_valid
);

    // Only 1, 2 or 4 lanes divide the four state words evenly.
    generate
        if (NUM_SBOX_WORDS != 1 && NUM_SBOX_WORDS != 2 && NUM_SBOX_WORDS != 4) begin : g_badLaneCount
            $error("aes_encipher_block_p: NUM_SBOX_WORDS must be 1, 2 or 4");
        end
    endgenerate

    localparam int         SBOX_CYCLES = 4 / NUM_SBOX_WORDS;
    localparam logic [1:0] LAST_CTR    = 2'(SBOX_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_stateNext;
    logic [127:0] r_block;
    logic [3:0]   r_round;
    logic [1:0]   r_ctr;
    logic [1:0]   r_keylen;
    logic         r_ready;
    logic         r_valid;

    logic [3:0]                   w_numRounds;
    logic                         w_lastRound;
    logic [32*NUM_SBOX_WORDS-1:0] w_sboxw;
    logic [127:0]                 w_subBlock;

    // GF(2^8) multiply by x.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte (column c, row r) moves from column (c + r) mod 4.
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        return o;
    endfunction

    // Standard AES column mix applied to each of the four words.
    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    assign w_numRounds  = (r_keylen == 2'd0) ? 4'd10 :
                          (r_keylen == 2'd1) ? 4'd12 : 4'd14;
    assign w_lastRound  = (r_round >= w_numRounds);

    assign round        = r_round;
    assign sboxw        = w_sboxw;
    assign new_block    = r_block;
    assign ready        = r_ready;
    assign result_valid = r_valid;

    // Route the current group of state words to the S-box lanes and merge the substituted words back.
    always_comb begin
        w_sboxw    = '0;
        w_subBlock = r_block;
        if (r_state == SBOX) begin
            for (int j = 0; j < NUM_SBOX_WORDS; j++) begin
                w_sboxw[32*(NUM_SBOX_WORDS - 1 - j) +: 32] =
                    r_block[32*(3 - (int'(r_ctr)*NUM_SBOX_WORDS + j)) +: 32];
                w_subBlock[32*(3 - (int'(r_ctr)*NUM_SBOX_WORDS + j)) +: 32] =
                    new_sboxw[32*(NUM_SBOX_WORDS - 1 - j) +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; abort always returns a busy engine to IDLE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE: begin
                if (next && !abort) begin
                    w_stateNext = INIT;
                end
            end
            INIT: begin
                w_stateNext = abort ? IDLE : SBOX;
            end
            SBOX: begin
                if (abort) begin
                    w_stateNext = IDLE;
                end else if (r_ctr == LAST_CTR) begin
                    w_stateNext = MAIN;
                end
            end
            MAIN: begin
                if (abort || w_lastRound) begin
                    w_stateNext = IDLE;
                end else begin
                    w_stateNext = SBOX;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Datapath registers: state block, round index, lane counter, latched key length and handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block  <= '0;
            r_round  <= '0;
            r_ctr    <= '0;
            r_keylen <= '0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (next && !abort) begin
                        r_round  <= 4'd0;
                        r_ready  <= 1'b0;
                        r_keylen <= keylen;
                    end
                end
                INIT: begin
                    if (abort) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_block <= block ^ round_key;
                        r_round <= 4'd1;
                        r_ctr   <= 2'd0;
                    end
                end
                SBOX: begin
                    if (abort) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_block <= w_subBlock;
                        r_ctr   <= (r_ctr == LAST_CTR) ? 2'd0 : r_ctr + 2'd1;
                    end
                end
                MAIN: begin
                    if (abort) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                        r_ctr   <= 2'd0;
                        if (w_lastRound) begin
                            r_block <= shiftRows(r_block) ^ round_key;
                            r_ready <= 1'b1;
                            r_valid <= 1'b1;
                        end else begin
                            r_block <= mixColumns(shiftRows(r_block)) ^ round_key;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encipher_block_p.sv
// Testbench for aes_encipher_block_p: three instances (1, 2 and 4 S-box lanes) run FIPS-197 vectors.
// The bench supplies the key schedule and S-box; a scoreboard checks every result_valid pulse.
module tb_aes_encipher_block_p;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic         nextV [3];
    logic         abort;
    logic [1:0]   keylen;
    logic [127:0] block;
    logic [3:0]   roundV [3];
    logic [127:0] roundKeyV [3];
    logic [127:0] newBlockV [3];
    logic         readyV [3];
    logic         validV [3];
    logic [31:0]  sboxw1, newSboxw1;
    logic [63:0]  sboxw2, newSboxw2;
    logic [127:0] sboxw4, newSboxw4;
    logic [127:0] tbRoundKeys [16];

    typedef struct {
        int           dut;
        logic [127:0] ct;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   fails  = 0;

    // GF(2^8) multiply.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    // AES S-box from its definition: inverse as x^254, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv, pw;
        logic [7:0] e;
        inv = 8'h01;
        pw  = x;
        e   = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, pw);
            pw = gmul(pw, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    assign newSboxw1    = subWord(sboxw1);
    assign newSboxw2    = {subWord(sboxw2[63:32]), subWord(sboxw2[31:0])};
    assign newSboxw4    = {subWord(sboxw4[127:96]), subWord(sboxw4[95:64]),
                           subWord(sboxw4[63:32]), subWord(sboxw4[31:0])};
    assign roundKeyV[0] = tbRoundKeys[roundV[0]];
    assign roundKeyV[1] = tbRoundKeys[roundV[1]];
    assign roundKeyV[2] = tbRoundKeys[roundV[2]];

    aes_encipher_block_p #(.NUM_SBOX_WORDS(1)) dut1 (
        .clk(clk), .reset(reset), .next(nextV[0]), .abort(abort), .keylen(keylen),
        .round(roundV[0]), .round_key(roundKeyV[0]), .block(block),
        .sboxw(sboxw1), .new_sboxw(newSboxw1), .new_block(newBlockV[0]),
        .ready(readyV[0]), .result_valid(validV[0])
    );

    aes_encipher_block_p #(.NUM_SBOX_WORDS(2)) dut2 (
        .clk(clk), .reset(reset), .next(nextV[1]), .abort(abort), .keylen(keylen),
        .round(roundV[1]), .round_key(roundKeyV[1]), .block(block),
        .sboxw(sboxw2), .new_sboxw(newSboxw2), .new_block(newBlockV[1]),
        .ready(readyV[1]), .result_valid(validV[1])
    );

    aes_encipher_block_p #(.NUM_SBOX_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .next(nextV[2]), .abort(abort), .keylen(keylen),
        .round(roundV[2]), .round_key(roundKeyV[2]), .block(block),
        .sboxw(sboxw4), .new_sboxw(newSboxw4), .new_block(newBlockV[2]),
        .ready(readyV[2]), .result_valid(validV[2])
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Expand the cipher key into per-round keys indexed by round number.
    task automatic loadKey(input logic [255:0] key, input logic [1:0] kl);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int          nk, nr;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                temp = w[i-1];
                if (i % nk == 0) begin
                    temp = subWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                    rc   = gmul(rc, 8'h02);
                end else if (nk == 8 && i % nk == 4) begin
                    temp = subWord(temp);
                end
                w[i] = w[i-nk] ^ temp;
            end
        end
        for (int r = 0; r < 16; r++) begin
            tbRoundKeys[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    // Pulse next for one instance; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input int d, input logic [1:0] kl);
        @(negedge clk);
        keylen   = kl;
        block    = PT;
        nextV[d] = 1'b1;
        @(posedge clk);
        #1;
        nextV[d] = 1'b0;
    endtask

    // One full encipher on instance d with latency, round-sequence and strobe checks.
    task automatic runCipher(input int d, input logic [1:0] kl, input logic [127:0] ct,
                             input int latency, input int nr, input bit busyNext,
                             input bit flipKeylen, input bit countSbox);
        int         edges;
        int         sboxCount;
        bit         roundOk;
        logic [3:0] prev;
        expQ.push_back('{dut: d, ct: ct});
        applyStimulus(d, kl);
        checkOutput("ready low after start", readyV[d], 0);
        checkOutput("round zero at INIT", roundV[d], 0);
        edges     = 0;
        sboxCount = 0;
        roundOk   = 1'b1;
        prev      = roundV[d];
        while (readyV[d] !== 1'b1 && edges < 200) begin
            nextV[d] = (busyNext && edges >= 3 && edges < 20) ? 1'b1 : 1'b0;
            if (flipKeylen && edges == 3) keylen = kl ^ 2'b11;
            @(posedge clk);
            #1;
            edges++;
            if (roundV[d] != prev && roundV[d] != prev + 4'd1) roundOk = 1'b0;
            prev = roundV[d];
            if (d == 2 && sboxw4 != 128'h0) sboxCount++;
        end
        nextV[d] = 1'b0;
        keylen   = kl;
        checkOutput("latency edges", edges, latency);
        checkOutput("result_valid with ready", validV[d], 1);
        checkOutput("round steps by one", roundOk, 1);
        checkOutput("round after completion", roundV[d], nr + 1);
        if (countSbox) checkOutput("sboxw nonzero cycles", sboxCount, nr);
        @(posedge clk);
        #1;
        checkOutput("result_valid one cycle", validV[d], 0);
    endtask

    // Scoreboard monitor: every result_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (validV[d] === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected result_valid", validV[d], 0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("scoreboard instance", d, monE.dut);
                    checkOutput("scoreboard ciphertext", newBlockV[d], monE.ct);
                    checkOutput("scoreboard ready", readyV[d], 1);
                end
            end
        end
    end

    // Directed test sequence.
    initial begin
        logic [127:0] held;
        int           guard;
        for (int d = 0; d < 3; d++) nextV[d] = 1'b0;
        abort  = 1'b0;
        keylen = 2'd0;
        block  = PT;
        for (int r = 0; r < 16; r++) tbRoundKeys[r] = 128'h0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset ready", readyV[d], 1);
            checkOutput("reset result_valid", validV[d], 0);
            checkOutput("reset round", roundV[d], 0);
            checkOutput("reset new_block", newBlockV[d], 0);
        end
        checkOutput("reset sboxw N1", sboxw1, 0);
        checkOutput("reset sboxw N2", sboxw2, 0);
        checkOutput("reset sboxw N4", sboxw4, 0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] FIPS-197 C.1 on N=1");
        loadKey(KEY1, 2'd0);
        runCipher(0, 2'd0, CT1, 51, 10, 1'b0, 1'b0, 1'b0);

        $display("[TB] FIPS-197 C.2 on N=2");
        loadKey(KEY2, 2'd1);
        runCipher(1, 2'd1, CT2, 37, 12, 1'b0, 1'b0, 1'b0);

        $display("[TB] FIPS-197 C.3 on N=4, keylen 2 and 3");
        loadKey(KEY3, 2'd2);
        runCipher(2, 2'd2, CT3, 29, 14, 1'b0, 1'b0, 1'b1);
        runCipher(2, 2'd3, CT3, 29, 14, 1'b0, 1'b0, 1'b1);

        $display("[TB] abort during SBOX of round 5, then restart");
        loadKey(KEY1, 2'd0);
        applyStimulus(0, 2'd0);
        guard = 0;
        while (roundV[0] != 4'd5 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("reached round 5", roundV[0], 5);
        held  = newBlockV[0];
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort ready", readyV[0], 1);
        checkOutput("abort result_valid", validV[0], 0);
        checkOutput("abort round holds", roundV[0], 5);
        checkOutput("abort new_block holds", newBlockV[0], held);
        runCipher(0, 2'd0, CT1, 51, 10, 1'b0, 1'b0, 1'b0);

        $display("[TB] next pulsed while busy");
        runCipher(0, 2'd0, CT1, 51, 10, 1'b1, 1'b0, 1'b0);

        $display("[TB] keylen changed mid-operation");
        runCipher(0, 2'd0, CT1, 51, 10, 1'b0, 1'b1, 1'b0);

        $display("[TB] next and abort together in IDLE");
        @(negedge clk);
        nextV[0] = 1'b1;
        abort    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nextV[0] = 1'b0;
        abort    = 1'b0;
        checkOutput("next+abort idle ready", readyV[0], 1);
        checkOutput("next+abort idle round", roundV[0], 11);

        $display("[TB] asynchronous reset in MAIN");
        applyStimulus(0, 2'd0);
        guard = 0;
        while (roundV[0] != 4'd3 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("reached round 3", roundV[0], 3);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("sboxw zero in MAIN", sboxw1, 0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset ready", readyV[0], 1);
        checkOutput("async reset result_valid", validV[0], 0);
        checkOutput("async reset round", roundV[0], 0);
        checkOutput("async reset new_block", newBlockV[0], 0);
        checkOutput("async reset sboxw", sboxw1, 0);
        @(negedge clk);
        reset = 1'b0;
        runCipher(0, 2'd0, CT1, 51, 10, 1'b0, 1'b0, 1'b0);
        runCipher(0, 2'd0, CT1, 51, 10, 1'b0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
